// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   N-digit BCD up/down counter with run/pause, speed levels, synchronous
//   load and a multiplexed active-low 7-segment driver. Everything runs on
//   i_clk; the count rate and the digit scan are tick enables from two free
//   running prescalers.
//
//   Optional feature macro: WRAP_EN
//     undefined : count saturates at all-9s (up) / all-0s (down), the
//                 o_max/o_min flags are levels.
//     defined   : count wraps, and o_max/o_min are one-cycle carry/borrow
//                 pulses on the wrap tick.
//
// Ports
//   i_clk               system clock
//   i_rst               synchronous active-high reset
//   i_en_pulse          toggle run/pause
//   i_dir               0 = up, 1 = down (sampled on tick)
//   i_speed_up_pulse    speed + 1 (saturating)
//   i_speed_down_pulse  speed - 1 (saturating)
//   i_load_pulse        load i_load_value (nibbles > 9 clamp to 9)
//   i_load_value        BCD preset, nibble 0 least significant
//   o_count             current BCD value
//   o_running           1 = counting
//   o_speed             current speed level (0 = slowest)
//   o_max / o_min       upper / lower bound flags
//   o_digit             active-low one-hot digit enable
//   o_display           active-low segments, gfedcba
module bcd_updown_counter #(
    parameter int NUM_DIGITS    = 4,
    parameter int SPEED_LEVELS  = 3,
    parameter int BASE_DIV_LOG2 = 23,
    parameter int SCAN_DIV_LOG2 = 10
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en_pulse,
    input  logic                            i_dir,
    input  logic                            i_speed_up_pulse,
    input  logic                            i_speed_down_pulse,
    input  logic                            i_load_pulse,
    input  logic [4*NUM_DIGITS-1:0]         i_load_value,
    output logic [4*NUM_DIGITS-1:0]         o_count,
    output logic                            o_running,
    output logic [$clog2(SPEED_LEVELS)-1:0] o_speed,
    output logic                            o_max,
    output logic                            o_min,
    output logic [NUM_DIGITS-1:0]           o_digit,
    output logic [6:0]                      o_display
);

    localparam int SW  = $clog2(SPEED_LEVELS);
    localparam int PW  = BASE_DIV_LOG2 + SPEED_LEVELS - 1;   // prescaler width, slowest period
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCW = (SCAN_DIV_LOG2 > 0) ? SCAN_DIV_LOG2 : 1;

    localparam logic [PW:0]    ONE_P     = 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'((1 << SCAN_DIV_LOG2) - 1);
    localparam logic [SW-1:0]  SPEED_TOP = SW'(SPEED_LEVELS - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0] r_count;
    logic                    r_running, r_max, r_min;
    logic [SW-1:0]           r_speed;
    logic [PW-1:0]           r_presc;
    logic [SCW-1:0]          r_scan;
    logic [IW-1:0]           r_idx;
    logic [NUM_DIGITS-1:0]   r_digit;
    logic [6:0]              r_display;

    logic [4*NUM_DIGITS-1:0] w_inc, w_dec, w_load, w_count_nxt;
    logic                    w_all9, w_all0;
    logic [PW:0]             w_period_m1;
    logic                    w_tick, w_spd_up, w_spd_dn;
    logic                    w_max_nxt, w_min_nxt;
    logic [SW-1:0]           w_speed_nxt;
    logic [PW-1:0]           w_presc_nxt;
    logic [SCW-1:0]          w_scan_nxt;
    logic [IW-1:0]           w_idx_nxt;

    // Ripple BCD increment/decrement; the final carry/borrow doubles as the
    // all-9s / all-0s detect.
    always_comb begin
        logic c, b;
        logic [3:0] n;
        c = 1'b1;
        b = 1'b1;
        w_inc  = r_count;
        w_dec  = r_count;
        w_load = i_load_value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            n = r_count[4*i +: 4];
            if (c) begin
                if (n == 4'd9) w_inc[4*i +: 4] = 4'd0;
                else begin
                    w_inc[4*i +: 4] = n + 4'd1;
                    c = 1'b0;
                end
            end
            if (b) begin
                if (n == 4'd0) w_dec[4*i +: 4] = 4'd9;
                else begin
                    w_dec[4*i +: 4] = n - 4'd1;
                    b = 1'b0;
                end
            end
            if (i_load_value[4*i +: 4] > 4'd9) w_load[4*i +: 4] = 4'd9;
        end
        w_all9 = c;
        w_all0 = b;
    end

    // Period is a power of two, so P-1 is a mask; compared one bit wider so
    // the slowest setting (P = 2^PW) still fits.
    always_comb begin
        w_period_m1 = (ONE_P << (PW - int'(r_speed))) - ONE_P;
        w_tick      = ({1'b0, r_presc} == w_period_m1);
        w_spd_up    = i_speed_up_pulse & ~i_speed_down_pulse & (r_speed != SPEED_TOP);
        w_spd_dn    = i_speed_down_pulse & ~i_speed_up_pulse & (r_speed != '0);
    end

    // Priority: load > speed change > tick.
    always_comb begin
        w_count_nxt = r_count;
        w_speed_nxt = r_speed;
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
`ifdef WRAP_EN
        // flags are single-cycle carry/borrow pulses
        w_max_nxt   = 1'b0;
        w_min_nxt   = 1'b0;
`else
        w_max_nxt   = r_max;
        w_min_nxt   = r_min;
`endif
        if (i_load_pulse) begin
            w_count_nxt = w_load;
            w_max_nxt   = 1'b0;
            w_min_nxt   = 1'b0;
            w_presc_nxt = '0;
        end else if (w_spd_up) begin
            w_speed_nxt = r_speed + 1'b1;
            w_presc_nxt = '0;
        end else if (w_spd_dn) begin
            w_speed_nxt = r_speed - 1'b1;
            w_presc_nxt = '0;
        end else if (w_tick && r_running) begin
            if (!i_dir) begin
`ifdef WRAP_EN
                w_count_nxt = w_inc;
                w_max_nxt   = w_all9;
`else
                if (w_all9) begin
                    w_max_nxt = 1'b1;
                    w_min_nxt = 1'b0;
                end else begin
                    w_count_nxt = w_inc;
                    w_max_nxt   = 1'b0;
                    w_min_nxt   = 1'b0;
                end
`endif
            end else begin
`ifdef WRAP_EN
                w_count_nxt = w_dec;
                w_min_nxt   = w_all0;
`else
                if (w_all0) begin
                    w_min_nxt = 1'b1;
                    w_max_nxt = 1'b0;
                end else begin
                    w_count_nxt = w_dec;
                    w_max_nxt   = 1'b0;
                    w_min_nxt   = 1'b0;
                end
`endif
            end
        end
    end

    // Scan position; display is built from next-state values so DIGIT and
    // DISPLAY always agree with the registered count.
    always_comb begin
        w_scan_nxt = (r_scan == SCAN_LAST) ? '0 : r_scan + 1'b1;
        w_idx_nxt  = r_idx;
        if (r_scan == SCAN_LAST)
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_running <= 1'b0;
            r_speed   <= '0;
            r_max     <= 1'b0;
            r_min     <= 1'b0;
            r_presc   <= '0;
            r_scan    <= '0;
            r_idx     <= '0;
            r_digit   <= ~NUM_DIGITS'(1);
            r_display <= 7'h40;
        end else begin
            r_count   <= w_count_nxt;
            r_running <= r_running ^ i_en_pulse;
            r_speed   <= w_speed_nxt;
            r_max     <= w_max_nxt;
            r_min     <= w_min_nxt;
            r_presc   <= w_presc_nxt;
            r_scan    <= w_scan_nxt;
            r_idx     <= w_idx_nxt;
            r_digit   <= ~(NUM_DIGITS'(1) << w_idx_nxt);
            r_display <= f_seg(w_count_nxt[4*w_idx_nxt +: 4]);
        end
    end

    assign o_count   = r_count;
    assign o_running = r_running;
    assign o_speed   = r_speed;
    assign o_max     = r_max;
    assign o_min     = r_min;
    assign o_digit   = r_digit;
    assign o_display = r_display;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

    localparam int ND = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, dir = 1'b0, up = 1'b0, dn = 1'b0, ld = 1'b0;
    logic [7:0]    ld_val = 8'h00;
    logic [7:0]    count;
    logic          running, maxf, minf;
    logic [1:0]    speed;
    logic [ND-1:0] digit;
    logic [6:0]    display;

    int checks   = 0;
    int failures = 0;

    bcd_updown_counter #(
        .NUM_DIGITS(ND), .SPEED_LEVELS(3), .BASE_DIV_LOG2(2), .SCAN_DIV_LOG2(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en_pulse(en), .i_dir(dir),
        .i_speed_up_pulse(up), .i_speed_down_pulse(dn),
        .i_load_pulse(ld), .i_load_value(ld_val),
        .o_count(count), .o_running(running), .o_speed(speed),
        .o_max(maxf), .o_min(minf), .o_digit(digit), .o_display(display)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // advance n clock edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (count !== 8'h00) begin
            failures++; $display("FAIL reset_count got=%h exp=00", count);
        end
        checks++;
        if ({running, speed, maxf, minf} !== 5'b0) begin
            failures++; $display("FAIL reset_state got=%b exp=00000", {running, speed, maxf, minf});
        end
        checks++;
        if ({digit, display} !== {2'b10, 7'h40}) begin
            failures++; $display("FAIL reset_scan got=%b/%h exp=10/40", digit, display);
        end
    endtask

    task automatic test_count_up;
        dir = 1'b0;
        en = 1'b1; step(1); en = 1'b0;
        checks++;
        if (running !== 1'b1) begin
            failures++; $display("FAIL up_running got=%b exp=1", running);
        end
        step(14);
        checks++;
        if (count !== 8'h00) begin
            failures++; $display("FAIL up_before_tick got=%h exp=00", count);
        end
        step(1);
        checks++;
        if (count !== 8'h01) begin
            failures++; $display("FAIL up_first_tick got=%h exp=01", count);
        end
        step(97 * 16);
        checks++;
        if (count !== 8'h98) begin
            failures++; $display("FAIL up_98 got=%h exp=98", count);
        end
        step(16);
        checks++;
        if ({count, maxf} !== {8'h99, 1'b0}) begin
            failures++; $display("FAIL up_99 got=%h max=%b exp=99 max=0", count, maxf);
        end
        step(16);
`ifdef WRAP_EN
        checks++;
        if ({count, maxf, minf} !== {8'h00, 1'b1, 1'b0}) begin
            failures++; $display("FAIL up_wrap got=%h max=%b min=%b exp=00 1 0", count, maxf, minf);
        end
        step(1);
        checks++;
        if (maxf !== 1'b0) begin
            failures++; $display("FAIL up_wrap_pulse got=%b exp=0", maxf);
        end
`else
        checks++;
        if ({count, maxf, minf} !== {8'h99, 1'b1, 1'b0}) begin
            failures++; $display("FAIL up_bound got=%h max=%b min=%b exp=99 1 0", count, maxf, minf);
        end
`endif
    endtask

    task automatic test_load_down;
        logic [7:0] exp_c;
        dir = 1'b1;
        ld_val = 8'h05; ld = 1'b1; step(1); ld = 1'b0;
        checks++;
        if ({count, maxf, minf} !== {8'h05, 2'b00}) begin
            failures++; $display("FAIL load_05 got=%h max=%b min=%b exp=05 0 0", count, maxf, minf);
        end
        for (int k = 4; k >= 0; k--) begin
            step(16);
            exp_c = {4'h0, 4'(k)};
            checks++;
            if (count !== exp_c) begin
                failures++; $display("FAIL down_step got=%h exp=%h", count, exp_c);
            end
        end
        checks++;
        if (minf !== 1'b0) begin
            failures++; $display("FAIL down_00_min got=%b exp=0", minf);
        end
        step(16);
`ifdef WRAP_EN
        checks++;
        if ({count, maxf, minf} !== {8'h99, 1'b0, 1'b1}) begin
            failures++; $display("FAIL down_wrap got=%h max=%b min=%b exp=99 0 1", count, maxf, minf);
        end
        step(1);
        checks++;
        if (minf !== 1'b0) begin
            failures++; $display("FAIL down_wrap_pulse got=%b exp=0", minf);
        end
`else
        checks++;
        if ({count, maxf, minf} !== {8'h00, 1'b0, 1'b1}) begin
            failures++; $display("FAIL down_bound got=%h max=%b min=%b exp=00 0 1", count, maxf, minf);
        end
`endif
        ld_val = 8'hA3; ld = 1'b1; step(1); ld = 1'b0;
        checks++;
        if ({count, maxf, minf, running} !== {8'h93, 3'b001}) begin
            failures++; $display("FAIL load_clamp got=%h max=%b min=%b run=%b exp=93 0 0 1", count, maxf, minf, running);
        end
    endtask

    task automatic test_speed;
        dir = 1'b0;
        up = 1'b1; step(1); up = 1'b0;
        checks++;
        if (speed !== 2'd1) begin
            failures++; $display("FAIL speed_up1 got=%0d exp=1", speed);
        end
        up = 1'b1; step(1); up = 1'b0;
        up = 1'b1; step(1); up = 1'b0;
        checks++;
        if ({speed, count} !== {2'd2, 8'h93}) begin
            failures++; $display("FAIL speed_sat got=%0d/%h exp=2/93", speed, count);
        end
        // ignored third pulse must not have cleared the prescaler
        step(2);
        checks++;
        if (count !== 8'h93) begin
            failures++; $display("FAIL fast_pre got=%h exp=93", count);
        end
        step(1);
        checks++;
        if (count !== 8'h94) begin
            failures++; $display("FAIL fast_tick1 got=%h exp=94", count);
        end
        step(4);
        checks++;
        if (count !== 8'h95) begin
            failures++; $display("FAIL fast_tick2 got=%h exp=95", count);
        end
        up = 1'b1; dn = 1'b1; step(1); up = 1'b0; dn = 1'b0;
        checks++;
        if (speed !== 2'd2) begin
            failures++; $display("FAIL speed_both got=%0d exp=2", speed);
        end
        step(2);
        checks++;
        if (count !== 8'h95) begin
            failures++; $display("FAIL both_pre got=%h exp=95", count);
        end
        step(1);
        checks++;
        if (count !== 8'h96) begin
            failures++; $display("FAIL both_tick got=%h exp=96", count);
        end
    endtask

    task automatic test_pause_same_cycle;
        step(3);
        en = 1'b1; step(1); en = 1'b0;
        checks++;
        if ({count, running} !== {8'h97, 1'b0}) begin
            failures++; $display("FAIL pause_tick got=%h run=%b exp=97 0", count, running);
        end
        step(8);
        checks++;
        if ({count, maxf, minf} !== {8'h97, 2'b00}) begin
            failures++; $display("FAIL paused_hold got=%h max=%b min=%b exp=97 0 0", count, maxf, minf);
        end
    endtask

    task automatic test_speed_down;
        dn = 1'b1; step(1); dn = 1'b0;
        checks++;
        if (speed !== 2'd1) begin
            failures++; $display("FAIL speed_dn1 got=%0d exp=1", speed);
        end
        dn = 1'b1; step(1); dn = 1'b0;
        dn = 1'b1; step(1); dn = 1'b0;
        checks++;
        if (speed !== 2'd0) begin
            failures++; $display("FAIL speed_dn_sat got=%0d exp=0", speed);
        end
    endtask

    task automatic test_scan;
        logic [1:0] exp_d;
        logic [6:0] exp_s;
        rst = 1'b1; step(1); rst = 1'b0;
        ld_val = 8'h37; ld = 1'b1; step(1); ld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if ((((i + 1) / 2) % 2) == 0) begin
                exp_d = 2'b10; exp_s = 7'h78;
            end else begin
                exp_d = 2'b01; exp_s = 7'h30;
            end
            checks++;
            if ({digit, display} !== {exp_d, exp_s}) begin
                failures++; $display("FAIL scan[%0d] got=%b/%h exp=%b/%h", i, digit, display, exp_d, exp_s);
            end
            if (i < 5) step(1);
        end
        rst = 1'b1; step(1); rst = 1'b0;
        checks++;
        if ({digit, display, count} !== {2'b10, 7'h40, 8'h00}) begin
            failures++; $display("FAIL scan_reset got=%b/%h/%h exp=10/40/00", digit, display, count);
        end
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_load_down;
        test_speed;
        test_pause_same_cycle;
        test_speed_down;
        test_scan;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
